cache_nway: RTL

//  Parametrised N-way set-associative, write-back, write-allocate data cache between CPU and line-wide main memory.
//  Way count and replacement policy (true LRU or FIFO) are selectable per instance; invalid ways are always filled first.
//  Hit/miss performance counters are exposed. The main-memory port is external, so main_mem attaches outside this block.

---
 rtl/cache_nway.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/cache_nway.sv
// N-way set-associative write-back / write-allocate data cache with
// selectable true-LRU or FIFO replacement and hit/miss counters.
module cache_nway #(
  parameter int LINE_ADDR_LEN = 3,
  parameter int SET_ADDR_LEN  = 3,
  parameter int TAG_ADDR_LEN  = 6,
  parameter int WAY_CNT       = 4,
  parameter int REPL_POLICY   = 0,
  parameter int CNT_W         = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [31:0]                          addr,
  input  logic                                 rd_req,
  input  logic                                 wr_req,
  input  logic [31:0]                          wr_data,
  output logic [31:0]                          rd_data,
  output logic                                 miss,
  output logic [TAG_ADDR_LEN+SET_ADDR_LEN-1:0] mem_addr,
  output logic                                 mem_rd_req,
  output logic                                 mem_wr_req,
  output logic [(32<<LINE_ADDR_LEN)-1:0]       mem_wr_line,
  input  logic [(32<<LINE_ADDR_LEN)-1:0]       mem_rd_line,
  input  logic                                 mem_gnt,
  output logic [CNT_W-1:0]                     hit_cnt,
  output logic [CNT_W-1:0]                     miss_cnt
);
  localparam int MEM_ADDR_LEN = TAG_ADDR_LEN + SET_ADDR_LEN;
  localparam int WORDS        = 1 << LINE_ADDR_LEN;
  localparam int SETS         = 1 << SET_ADDR_LEN;
  localparam int LINE_W       = 32 * WORDS;
  localparam int WAY_W        = (WAY_CNT > 1) ? $clog2(WAY_CNT) : 1;
  localparam int ADDR_HI      = TAG_ADDR_LEN + SET_ADDR_LEN + LINE_ADDR_LEN + 2;

  typedef enum logic [1:0] {IDLE, SWAP_OUT, SWAP_IN, SWAP_IN_OK} state_t;
  state_t state, state_nxt;

  logic [LINE_ADDR_LEN-1:0] word_idx;
  logic [SET_ADDR_LEN-1:0]  set_idx;
  logic [TAG_ADDR_LEN-1:0]  tag_in;
  logic                     unused_addr;

  assign word_idx    = addr[LINE_ADDR_LEN+1:2];
  assign set_idx     = addr[LINE_ADDR_LEN+SET_ADDR_LEN+1:LINE_ADDR_LEN+2];
  assign tag_in      = addr[ADDR_HI-1:LINE_ADDR_LEN+SET_ADDR_LEN+2];
  assign unused_addr = &{1'b0, addr[31:ADDR_HI], addr[1:0]};

  logic [31:0]             line_mem [SETS][WAY_CNT][WORDS];
  logic [TAG_ADDR_LEN-1:0] tag_mem  [SETS][WAY_CNT];
  logic [WAY_CNT-1:0]      valid    [SETS];
  logic [WAY_CNT-1:0]      dirty    [SETS];
  logic [WAY_W-1:0]        age      [SETS][WAY_CNT];
  logic [WAY_W-1:0]        fifo_ptr [SETS];

  logic                    hit, req, idle_hit, retry;
  logic [WAY_W-1:0]        hit_way, victim, fill_way;
  logic [TAG_ADDR_LEN-1:0] fill_tag;
  logic [SET_ADDR_LEN-1:0] fill_set;
  logic [MEM_ADDR_LEN-1:0] victim_addr;
  logic [LINE_W-1:0]       victim_line, fill_line;
  logic                    touch_en;
  logic [SET_ADDR_LEN-1:0] touch_set;
  logic [WAY_W-1:0]        touch_way;

  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAY_CNT; w++) begin
      if (valid[set_idx][w] && tag_mem[set_idx][w] == tag_in) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  // Policy choice first, then any invalid way (lowest index wins) overrides it.
  always_comb begin
    victim      = '0;
    victim_line = '0;
    if (REPL_POLICY == 0) begin
      for (int w = 0; w < WAY_CNT; w++)
        if (age[set_idx][w] == WAY_W'(WAY_CNT - 1)) victim = WAY_W'(w);
    end else begin
      victim = fifo_ptr[set_idx];
    end
    for (int w = WAY_CNT - 1; w >= 0; w--)
      if (!valid[set_idx][w]) victim = WAY_W'(w);
    for (int i = 0; i < WORDS; i++)
      victim_line[32*i +: 32] = line_mem[set_idx][victim][i];
  end

  assign req      = rd_req | wr_req;
  assign idle_hit = hit && (state == IDLE);
  assign miss     = req & ~idle_hit;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    mem_rd_req = 1'b0;
    mem_wr_req = 1'b0;
    mem_addr   = '0;
    case (state)
      IDLE: begin
        if (miss)
          state_nxt = (valid[set_idx][victim] && dirty[set_idx][victim]) ? SWAP_OUT : SWAP_IN;
      end
      SWAP_OUT: begin
        mem_wr_req = 1'b1;
        mem_addr   = victim_addr;
        if (mem_gnt) state_nxt = SWAP_IN;
      end
      SWAP_IN: begin
        mem_rd_req = 1'b1;
        mem_addr   = {fill_tag, fill_set};
        if (mem_gnt) state_nxt = SWAP_IN_OK;
      end
      SWAP_IN_OK: state_nxt = IDLE;
      default:    state_nxt = IDLE;
    endcase
  end

  // Recency is refreshed by a completed IDLE hit or by a line fill.
  always_comb begin
    touch_en  = 1'b0;
    touch_set = set_idx;
    touch_way = hit_way;
    if (state == IDLE && req && hit) begin
      touch_en = 1'b1;
    end else if (state == SWAP_IN_OK) begin
      touch_en  = 1'b1;
      touch_set = fill_set;
      touch_way = fill_way;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int s = 0; s < SETS; s++) begin
        valid[s]    <= '0;
        dirty[s]    <= '0;
        fifo_ptr[s] <= '0;
        for (int w = 0; w < WAY_CNT; w++) age[s][w] <= WAY_W'(w);
      end
      rd_data     <= '0;
      hit_cnt     <= '0;
      miss_cnt    <= '0;
      retry       <= 1'b0;
      mem_wr_line <= '0;
      victim_addr <= '0;
      fill_way    <= '0;
      fill_tag    <= '0;
      fill_set    <= '0;
    end else begin
      if (touch_en) begin
        for (int w = 0; w < WAY_CNT; w++)
          if (age[touch_set][w] < age[touch_set][touch_way])
            age[touch_set][w] <= age[touch_set][w] + WAY_W'(1);
        age[touch_set][touch_way] <= '0;
      end
      if (state == IDLE && req) begin
        if (hit) begin
          if (rd_req) rd_data <= line_mem[set_idx][hit_way][word_idx];
          else        dirty[set_idx][hit_way] <= 1'b1;
          if (!retry) hit_cnt <= hit_cnt + CNT_W'(1);
          retry <= 1'b0;
        end else begin
          miss_cnt <= miss_cnt + CNT_W'(1);
          fill_way <= victim;
          fill_tag <= tag_in;
          fill_set <= set_idx;
          if (valid[set_idx][victim] && dirty[set_idx][victim]) begin
            mem_wr_line <= victim_line;
            victim_addr <= {tag_mem[set_idx][victim], set_idx};
          end
        end
      end
      if (state == SWAP_IN_OK) begin
        valid[fill_set][fill_way] <= 1'b1;
        dirty[fill_set][fill_way] <= 1'b0;
        fifo_ptr[fill_set] <= (fifo_ptr[fill_set] == WAY_W'(WAY_CNT - 1)) ?
                              '0 : fifo_ptr[fill_set] + WAY_W'(1);
        retry <= 1'b1;
      end
    end
  end

  // Line storage and tags carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (state == IDLE && req && hit && !rd_req)
      line_mem[set_idx][hit_way][word_idx] <= wr_data;
    if (state == SWAP_IN && mem_gnt)
      fill_line <= mem_rd_line;
    if (state == SWAP_IN_OK) begin
      tag_mem[fill_set][fill_way] <= fill_tag;
      for (int i = 0; i < WORDS; i++)
        line_mem[fill_set][fill_way][i] <= fill_line[32*i +: 32];
    end
  end

endmodule
